// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and issues one outstanding imem read, feeding the IF/ID register.
// Latency: an imem ack in cycle N presents the word on fs_o_instr/fs_o_ce in cycle N+1.
// Backpressure: fs_i_stall holds a valid output; one extra word parks in a skid entry. Optional macro: FETCH_STAGE_MISALIGN_EN.
`ifndef IWIDTH
`define IWIDTH 32
`endif

module fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                fs_clk,
  input  logic                fs_rst,
  output logic                fs_o_imem_req,
  output logic [PC_WIDTH-1:0] fs_o_imem_addr,
  input  logic                fs_i_imem_ack,
  input  logic [`IWIDTH-1:0]  fs_i_imem_data,
  input  logic                fs_i_stall,
  input  logic                fs_i_redirect,
  input  logic [PC_WIDTH-1:0] fs_i_target,
  output logic [`IWIDTH-1:0]  fs_o_instr,
  output logic [PC_WIDTH-1:0] fs_o_pc,
  output logic [PC_WIDTH-1:0] fs_o_pc_plus4,
  output logic                fs_o_ce,
  output logic                fs_o_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, SKID, DROP} state_t;

  // Instruction addresses are word aligned; the low two bits of any target are dropped.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [`IWIDTH-1:0]  skid_instr;

  logic                can_load;
  logic                ack;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] target_al;

  // The IF/ID register may take a new word when it is empty or being consumed.
  assign can_load  = !fs_o_ce || !fs_i_stall;
  // Acks only count while a request is actually outstanding.
  assign ack       = fs_i_imem_ack && fs_o_imem_req;
  assign pc_inc    = pc + PC_WIDTH'(4);
  assign target_al = fs_i_target & ALIGN_MASK;

  // Fetch FSM: PC, request interface, skid entry and IF/ID output register.
  always_ff @(posedge fs_clk or negedge fs_rst) begin
    if (!fs_rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      fs_o_imem_req  <= 1'b0;
      fs_o_imem_addr <= RESET_PC;
      skid_pc        <= '0;
      skid_instr     <= '0;
      fs_o_instr     <= '0;
      fs_o_pc        <= '0;
      fs_o_pc_plus4  <= '0;
      fs_o_ce        <= 1'b0;
    end else if (fs_i_redirect) begin
      // Redirect wins over everything: flush output and skid, retarget the PC.
      fs_o_ce       <= 1'b0;
      pc            <= target_al;
      fs_o_imem_req <= 1'b1;
      if (fs_o_imem_req && !ack) begin
        // The read in flight must still complete at its old address, then be thrown away.
        state <= DROP;
      end else begin
        state          <= REQ;
        fs_o_imem_addr <= target_al;
      end
    end else begin
      case (state)
        IDLE: begin
          state          <= REQ;
          fs_o_imem_req  <= 1'b1;
          fs_o_imem_addr <= pc;
        end
        REQ: begin
          if (ack) begin
            pc             <= pc_inc;
            fs_o_imem_addr <= pc_inc;
            if (can_load) begin
              fs_o_instr    <= fs_i_imem_data;
              fs_o_pc       <= pc;
              fs_o_pc_plus4 <= pc_inc;
              fs_o_ce       <= 1'b1;
            end else begin
              // Output is stalled full: park the word and pause requests.
              skid_instr    <= fs_i_imem_data;
              skid_pc       <= pc;
              state         <= SKID;
              fs_o_imem_req <= 1'b0;
            end
          end else if (can_load) begin
            fs_o_ce <= 1'b0;
          end
        end
        SKID: begin
          if (can_load) begin
            fs_o_instr    <= skid_instr;
            fs_o_pc       <= skid_pc;
            fs_o_pc_plus4 <= skid_pc + PC_WIDTH'(4);
            fs_o_ce       <= 1'b1;
            state         <= REQ;
            fs_o_imem_req <= 1'b1;
          end
        end
        DROP: begin
          if (can_load) begin
            fs_o_ce <= 1'b0;
          end
          if (ack) begin
            state          <= REQ;
            fs_o_imem_addr <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STAGE_MISALIGN_EN
  logic misalign;

  // Flag a misaligned redirect target for exactly one cycle.
  always_ff @(posedge fs_clk or negedge fs_rst) begin
    if (!fs_rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= fs_i_redirect && (fs_i_target[1:0] != 2'b00);
    end
  end

  assign fs_o_misalign = misalign;
`else
  assign fs_o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory model.
`ifndef IWIDTH
`define IWIDTH 32
`endif

module tb_fetch_stage;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               req;
  logic [31:0]        addr;
  logic               ack;
  logic [`IWIDTH-1:0] data;
  logic               stall = 1'b0;
  logic               redirect = 1'b0;
  logic [31:0]        target = '0;
  logic [`IWIDTH-1:0] instr;
  logic [31:0]        o_pc;
  logic [31:0]        plus4;
  logic               ce;
  logic               misalign;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt    = 0;
  int wait_n = 0;
  logic exp_mis;

  fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .fs_clk        (clk),
    .fs_rst        (rst),
    .fs_o_imem_req (req),
    .fs_o_imem_addr(addr),
    .fs_i_imem_ack (ack),
    .fs_i_imem_data(data),
    .fs_i_stall    (stall),
    .fs_i_redirect (redirect),
    .fs_i_target   (target),
    .fs_o_instr    (instr),
    .fs_o_pc       (o_pc),
    .fs_o_pc_plus4 (plus4),
    .fs_o_ce       (ce),
    .fs_o_misalign (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: acks after wait_n extra cycles of a held request.
  assign ack  = req && (cnt == wait_n);
  assign data = ack ? tag(addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!req || ack) cnt <= 0;
    else             cnt <= cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ce", ce, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_plus4", plus4, 0);
    chk("rst_mis", misalign, 0);
  endtask

  // Release reset just after an edge; returns in the first (IDLE) cycle.
  task automatic start(input int w);
    wait_n   = w;
    stall    = 1'b0;
    redirect = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
`ifdef FETCH_STAGE_MISALIGN_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    #1;
    check_reset_vals();

    // Zero-wait streaming
    start(0);
    chk("t1_idle_req", req, 0);
    cyc();
    chk("t1_c2_req", req, 1);
    chk("t1_c2_addr", addr, 32'h0);
    chk("t1_c2_ce", ce, 0);
    cyc();
    chk("t1_c3_ce", ce, 1);
    chk("t1_c3_pc", o_pc, 32'h0);
    chk("t1_c3_instr", instr, tag(32'h0));
    chk("t1_c3_plus4", plus4, 32'h4);
    cyc();
    chk("t1_c4_pc", o_pc, 32'h4);
    cyc();
    chk("t1_c5_pc", o_pc, 32'h8);
    chk("t1_c5_plus4", plus4, 32'hC);
    chk("t1_c5_instr", instr, tag(32'h8));

    // Asynchronous reset in the middle of a stream
    rst = 1'b0;
    #1;
    check_reset_vals();

    // Three-cycle memory latency
    start(2);
    cyc();
    chk("t2_c2_addr", addr, 32'h0);
    cyc();
    chk("t2_c3_req", req, 1);
    chk("t2_c3_addr", addr, 32'h0);
    chk("t2_c3_ce", ce, 0);
    cyc();
    chk("t2_c4_ce", ce, 0);
    cyc();
    chk("t2_c5_ce", ce, 1);
    chk("t2_c5_pc", o_pc, 32'h0);
    chk("t2_c5_addr", addr, 32'h4);
    cyc();
    chk("t2_c6_ce", ce, 0);
    cyc();
    chk("t2_c7_ce", ce, 0);
    cyc();
    chk("t2_c8_ce", ce, 1);
    chk("t2_c8_pc", o_pc, 32'h4);
    chk("t2_c8_instr", instr, tag(32'h4));
    chk("t2_c8_addr", addr, 32'h8);

    // Redirect while the request to 0x8 is pending
    redirect = 1'b1;
    target   = 32'h100;
    cyc();
    redirect = 1'b0;
    chk("t4_c9_ce", ce, 0);
    chk("t4_c9_req", req, 1);
    chk("t4_c9_addr", addr, 32'h8);
    cyc();
    chk("t4_c10_ce", ce, 0);
    chk("t4_c10_ack", ack, 1);
    cyc();
    chk("t4_c11_ce", ce, 0);
    chk("t4_c11_addr", addr, 32'h100);
    cyc();
    chk("t4_c12_ce", ce, 0);
    cyc();
    chk("t4_c13_ce", ce, 0);
    cyc();
    chk("t4_c14_ce", ce, 1);
    chk("t4_c14_pc", o_pc, 32'h100);
    chk("t4_c14_instr", instr, tag(32'h100));

    // Stall for four cycles while acks arrive
    rst = 1'b0;
    #1;
    start(0);
    cyc();
    cyc();
    chk("t3_c3_pc", o_pc, 32'h0);
    stall = 1'b1;
    cyc();
    chk("t3_c4_req", req, 0);
    chk("t3_c4_ce", ce, 1);
    chk("t3_c4_pc", o_pc, 32'h0);
    cyc();
    cyc();
    chk("t3_c6_pc", o_pc, 32'h0);
    chk("t3_c6_instr", instr, tag(32'h0));
    chk("t3_c6_req", req, 0);
    cyc();
    stall = 1'b0;
    cyc();
    chk("t3_c8_pc", o_pc, 32'h4);
    chk("t3_c8_instr", instr, tag(32'h4));
    chk("t3_c8_ce", ce, 1);
    chk("t3_c8_addr", addr, 32'h8);
    cyc();
    chk("t3_c9_pc", o_pc, 32'h8);
    cyc();
    chk("t3_c10_pc", o_pc, 32'hC);

    // Redirect together with ack and stall, then redirect with a full skid
    rst = 1'b0;
    #1;
    start(0);
    cyc();
    cyc();
    chk("t5_c3_ack", ack, 1);
    stall    = 1'b1;
    redirect = 1'b1;
    target   = 32'h200;
    cyc();
    redirect = 1'b0;
    chk("t5_c4_ce", ce, 0);
    chk("t5_c4_addr", addr, 32'h200);
    chk("t5_c4_req", req, 1);
    cyc();
    chk("t5_c5_ce", ce, 1);
    chk("t5_c5_pc", o_pc, 32'h200);
    chk("t5_c5_instr", instr, tag(32'h200));
    cyc();
    chk("t5_c6_req", req, 0);
    chk("t5_c6_pc", o_pc, 32'h200);
    redirect = 1'b1;
    target   = 32'h300;
    cyc();
    redirect = 1'b0;
    chk("t5_c7_ce", ce, 0);
    chk("t5_c7_addr", addr, 32'h300);
    cyc();
    chk("t5_c8_ce", ce, 1);
    chk("t5_c8_pc", o_pc, 32'h300);
    stall = 1'b0;
    cyc();
    chk("t5_c9_pc", o_pc, 32'h304);

    // Misaligned target, then PC wrap-around
    rst = 1'b0;
    #1;
    start(0);
    cyc();
    cyc();
    chk("t6_c3_mis", misalign, 0);
    redirect = 1'b1;
    target   = 32'h102;
    cyc();
    redirect = 1'b0;
    chk("t6_c4_mis", misalign, exp_mis);
    chk("t6_c4_addr", addr, 32'h100);
    chk("t6_c4_ce", ce, 0);
    cyc();
    chk("t6_c5_mis", misalign, 0);
    chk("t6_c5_pc", o_pc, 32'h100);
    redirect = 1'b1;
    target   = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    chk("t6_c6_mis", misalign, 0);
    chk("t6_c6_addr", addr, 32'hFFFF_FFFC);
    cyc();
    chk("t6_c7_pc", o_pc, 32'hFFFF_FFFC);
    chk("t6_c7_plus4", plus4, 32'h0);
    chk("t6_c7_addr", addr, 32'h0);
    cyc();
    chk("t6_c8_pc", o_pc, 32'h0);
    chk("t6_c8_instr", instr, tag(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
